// File: rtl/gpio_reg_bus_initiator_if.sv
// Command, response and decoder-bus signals of the GPIO register bus initiator.
// The master modport is the initiator's view; slave is the peer's view.
interface gpio_reg_bus_initiator_if #(
    parameter int AddrWidth = 16,
    parameter int BusWidth  = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic                   cmd_verify;
    logic [AddrWidth-3:0]   cmd_addr;
    logic [BusWidth-1:0]    cmd_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [BusWidth-1:0]    rsp_data;
    logic [1:0]             rsp_err;
    logic                   busy;
    logic                   chip_sel;
    logic                   write_reg;
    logic                   read_reg;
    logic [AddrWidth-3:0]   busaddress;
    logic [BusWidth-1:0]    busdata_out;
    logic [BusWidth-1:0]    busdata_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_verify, cmd_addr, cmd_data,
        input  rsp_ready, busdata_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        output chip_sel, write_reg, read_reg, busaddress, busdata_out
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_verify, cmd_addr, cmd_data,
        output rsp_ready, busdata_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  chip_sel, write_reg, read_reg, busaddress, busdata_out
    );
endinterface

// File: rtl/gpio_reg_bus_initiator.sv
// Bus master for the GPIO register decoder: paced write, read and
// write-then-verify cycles, one response per accepted command.
module gpio_reg_bus_initiator #(
    parameter int                  AddrWidth      = 16,
    parameter int                  BusWidth       = 32,
    parameter int                  WrStrobeCycles = 3,
    parameter int                  ReadLatency    = 4,
    parameter int                  GapCycles      = 2,
    parameter logic [BusWidth-1:0] VerifyMask     = 32'h3F3F3F3F
) (
    input  logic                    reg_clk,
    input  logic                    reset_in,
    gpio_reg_bus_initiator_if.master bus
);
    localparam int MaxWr  = (WrStrobeCycles > GapCycles) ? WrStrobeCycles : GapCycles;
    localparam int MaxCyc = (ReadLatency > MaxWr) ? ReadLatency : MaxWr;
    localparam int CntW   = $clog2(MaxCyc);

    localparam logic [CntW-1:0] WrLast  = CntW'(WrStrobeCycles - 1);
    localparam logic [CntW-1:0] RdLast  = CntW'(ReadLatency - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GapCycles - 1);

    localparam logic [AddrWidth-1:0] RegLo = AddrWidth'(32'h1100);
    localparam logic [AddrWidth-1:0] MuxLo = AddrWidth'(32'h1120);
    localparam logic [AddrWidth-1:0] RegHi = AddrWidth'(32'h1200);
    localparam logic [AddrWidth-1:0] AltLo = AddrWidth'(32'h1300);
    localparam logic [AddrWidth-1:0] AltHi = AddrWidth'(32'h1400);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_GAP,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic                   vfy_q, vfy_d;
    logic [BusWidth-1:0]    data_q, data_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [BusWidth-1:0]    rsp_data_q, rsp_data_d;
    logic [1:0]             rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;
    logic                   chip_sel_q, chip_sel_d;
    logic                   write_reg_q, write_reg_d;
    logic                   read_reg_q, read_reg_d;
    logic [AddrWidth-3:0]   busaddress_q, busaddress_d;
    logic [BusWidth-1:0]    busdata_out_q, busdata_out_d;

    logic [AddrWidth-1:0]   addr_b;
    logic                   reg_ok;
    logic                   mux_ok;
    logic                   addr_ok;
    logic                   vfy_bad;

    assign addr_b  = {bus.cmd_addr, 2'b00};
    assign mux_ok  = (addr_b >= MuxLo) && (addr_b < RegHi);
    assign reg_ok  = ((addr_b >= RegLo) && (addr_b < RegHi)) ||
                     ((addr_b >= AltLo) && (addr_b < AltHi));
    // Reads and readbacks only make sense on the mux registers.
    assign addr_ok = (bus.cmd_write && !bus.cmd_verify) ? reg_ok : mux_ok;
    assign vfy_bad = |((bus.busdata_in ^ data_q) & VerifyMask);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CntW'(1);
        wr_d          = wr_q;
        vfy_d         = vfy_q;
        data_d        = data_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        busaddress_d  = busaddress_q;
        busdata_out_d = busdata_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    wr_d       = bus.cmd_write;
                    vfy_d      = bus.cmd_write && bus.cmd_verify;
                    data_d     = bus.cmd_data;
                    rsp_err_d  = 2'b00;
                    rsp_data_d = bus.cmd_write ? bus.cmd_data : '0;
                    if (!addr_ok) begin
                        rsp_err_d = 2'b01;
                        state_d   = S_RESP;
                    end else begin
                        busaddress_d = bus.cmd_addr;
                        if (bus.cmd_write) begin
                            busdata_out_d = bus.cmd_data;
                            state_d       = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == WrLast) state_d = S_GAP;
            end
            S_READ: begin
                if (cnt_q == RdLast) begin
                    rsp_data_d = bus.busdata_in;
                    // Only a verify readback reaches READ with a write latched.
                    rsp_err_d  = (wr_q && vfy_bad) ? 2'b10 : 2'b00;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GapLast) begin
                    if (vfy_q) begin
                        vfy_d   = 1'b0;
                        state_d = S_READ;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        write_reg_d = (state_d == S_WRITE);
        read_reg_d  = (state_d == S_READ);
        chip_sel_d  = write_reg_d || read_reg_d;
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge reg_clk or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            vfy_q         <= 1'b0;
            data_q        <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 2'b00;
            busy_q        <= 1'b0;
            chip_sel_q    <= 1'b0;
            write_reg_q   <= 1'b0;
            read_reg_q    <= 1'b0;
            busaddress_q  <= '0;
            busdata_out_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            vfy_q         <= vfy_d;
            data_q        <= data_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            chip_sel_q    <= chip_sel_d;
            write_reg_q   <= write_reg_d;
            read_reg_q    <= read_reg_d;
            busaddress_q  <= busaddress_d;
            busdata_out_q <= busdata_out_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = busy_q;
    assign bus.chip_sel    = chip_sel_q;
    assign bus.write_reg   = write_reg_q;
    assign bus.read_reg    = read_reg_q;
    assign bus.busaddress  = busaddress_q;
    assign bus.busdata_out = busdata_out_q;
endmodule
